riscoffee_ram_dp: RTL
=====================

# riscoffee_ram_dp

Dual-port, byte-addressed 32-bit RAM that replaces the single shared-port RAM of the core. It gives instruction fetch a dedicated read port, so fetch no longer stalls behind loads and stores. The data port has an explicit request/ready/valid handshake, sized and sign/zero-extended loads, byte-lane stores, and optional hardware splitting of word-crossing misaligned accesses. It sits between the core's fetch/LSU stages and the on-chip memory array.

## Interface
- ADDR_WIDTH, 20, word-address bits; array depth 2^ADDR_WIDTH words of 32 bits
- INIT_FILE, "../hex/ram.hex", $readmemh image loaded at elaboration
- CLK  in  1  clock, all logic on rising edge
- RST  in  1  synchronous, active-high reset (one clock; reset is synchronous and active-high)
- I_REQ  in  1  instruction read request
- I_ADDR  in  32  fetch byte address; bits [1:0] ignored
- I_VALID  out  1  I_RDATA valid
- I_RDATA  out  32  fetched word
- D_REQ  in  1  data request
- D_WE  in  1  1 = store, 0 = load
- D_SIZE  in  2  00 byte, 01 half, 10 word, 11 reserved
- D_UNSIGNED  in  1  zero-extend byte/half loads
- D_ADDR  in  32  data byte address
- D_WDATA  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- D_READY  out  1  data port can accept a request this cycle
- D_VALID  out  1  data response strobe, exactly one per accepted request
- D_RDATA  out  32  extended load data; 0 for stores and errors
- D_ERR  out  1  request rejected, qualified by D_VALID

## Operation
- Word index = ADDR[ADDR_WIDTH+1:2]; higher address bits ignored. Byte offset = ADDR[1:0]; little-endian lanes.
- Handshake: a request is accepted on a cycle with D_REQ && D_READY. D_READY=1 in IDLE, 0 in SPLIT and while RST is high.
- FSM states:
  - IDLE: accepts requests.
  - SPLIT: second word of a crossing access.
  - Transitions: IDLE→SPLIT on accepting a crossing access with the macro enabled. SPLIT→IDLE unconditionally.
- Crossing access: offset + bytes > 4 (half at offset 3, word at offset 1–3).
- Non-crossing access: one array access. Byte enables:
  - byte: lane = offset.
  - half: lanes offset, offset+1 (offset 0–2).
  - word: all lanes.
- Load extension:
  - byte/half sign-extended from the top bit, or zero-extended if D_UNSIGNED.
  - Word loads are passed through unchanged.
- D_SIZE=11: D_ERR=1, no write, D_RDATA=0.
- Read-first array: a read and a write to the same word in the same cycle return the old data. This applies across ports too (I-read vs D-write).
- Writes commit on the accepting edge. A later load sees them.
- Memory contents are not cleared by RST.

## Timing
- Reset values: I_VALID=0, I_RDATA=0, D_VALID=0, D_RDATA=0, D_ERR=0, D_READY=0; FSM=IDLE.
- Instruction port: I_REQ at cycle t → I_VALID=1, I_RDATA at t+1. Back-to-back requests give one word per cycle. I_VALID=0 on cycles after no request.
- Data port, non-crossing: accept at t → D_VALID at t+1. Throughput is one request per cycle.
- Data port, crossing split:
  - Low word W is accessed at t, high word W+1 at t+1.
  - D_VALID with merged/extended data at t+2.
  - W+1 wraps modulo 2^ADDR_WIDTH.
- D_VALID, D_ERR and D_RDATA are held for one cycle only. There is no back-pressure on the response.
- RST in SPLIT:
  - FSM returns to IDLE.
  - The low-word write is already committed; the high-word write is dropped.
  - No D_VALID is produced for that request.
- RST asserted concurrently with D_REQ: the request is not accepted.

## Configuration
- RIPCPU_RAM_MISALIGN_EN defined:
  - Crossing accesses are split via SPLIT (2-cycle occupancy, 2-cycle latency).
  - Misaligned non-crossing accesses (e.g. half at offset 1) are served in one access.
- RIPCPU_RAM_MISALIGN_EN undefined:
  - SPLIT is absent.
  - Any access not naturally aligned (half at odd offset, word at offset ≠0) → D_VALID=1, D_ERR=1 at t+1, no write, D_RDATA=0.
  - D_READY is always 1 outside reset.

## Test plan
- Store word 0xDEADBEEF @0x100, then load byte @0x103 signed/unsigned → 0xFFFFFFDE / 0x000000DE, D_VALID one cycle after each accept.
- Store half 0x8001 @0x202, load word @0x200 (prior 0x0) → 0x80010000. Load half @0x202 signed → 0xFFFF8001.
- Same-cycle I_REQ @0x40 and D store word 0x12345678 @0x40 (old 0xAAAAAAAA) → I_RDATA=0xAAAAAAAA. Next I_REQ → 0x12345678.
- With macro: store word 0x11223344 @0x0FE, then load word @0x0FE:
  - Word 0x3F lanes 2–3 = 44,33; word 0x40 lanes 0–1 = 22,11.
  - D_READY=0 for one cycle; load returns 0x11223344 at t+2.
  - The same access at the top word wraps to word 0.
- Without macro: load word @0x101 → D_ERR=1, D_RDATA=0 at t+1. Store half @0x301 → memory unchanged. D_SIZE=11 → D_ERR=1 in both builds.
- With macro: assert RST during SPLIT of store @0x0FE:
  - Low lanes of word 0x3F are written; word 0x40 is unchanged.
  - No D_VALID is produced; D_READY returns to 1 after RST drops.

Source files
------------

// File: rtl/riscoffee_ram_dp_if.sv
// Bus bundle between the core (master) and the dual-port RAM (slave):
// instruction fetch read port plus the sized request/ready/valid data port.
interface riscoffee_ram_dp_if;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_valid;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [1:0]  d_size;
  logic        d_unsigned;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ready;
  logic        d_valid;
  logic [31:0] d_rdata;
  logic        d_err;

  modport master (
    output i_req, i_addr, d_req, d_we, d_size, d_unsigned, d_addr, d_wdata,
    input  i_valid, i_rdata, d_ready, d_valid, d_rdata, d_err
  );

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_size, d_unsigned, d_addr, d_wdata,
    output i_valid, i_rdata, d_ready, d_valid, d_rdata, d_err
  );
endinterface

// File: rtl/riscoffee_ram_dp.sv
// Dual-port byte-addressed 32-bit RAM: dedicated fetch read port plus a sized data port.
// Define RIPCPU_RAM_MISALIGN_EN to split word-crossing accesses in hardware; otherwise they error.
module riscoffee_ram_dp #(
  parameter int ADDR_WIDTH = 20,
  parameter     INIT_FILE  = "../hex/ram.hex"
) (
  input logic               clk,
  input logic               rst,
  riscoffee_ram_dp_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic {IDLE, SPLIT} state_t;
  state_t state;

  logic [31:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] d_word, i_word, hi_word, wr_idx, rd_idx;
  logic [1:0]  off, sv_off, sv_size;
  logic [2:0]  nbytes;
  logic [3:0]  lane_mask, wr_be, hi_be;
  logic [7:0]  be_pair;
  logic [63:0] wdata_pair;
  logic [31:0] wr_data, hi_data, rd_word, lo_data;
  logic        err, split_go, accept, wr_en, sv_unsigned, sv_we;
  logic        unused_addr;

  assign d_word      = bus.d_addr[ADDR_WIDTH+1:2];
  assign i_word      = bus.i_addr[ADDR_WIDTH+1:2];
  assign off         = bus.d_addr[1:0];
  assign unused_addr = ^{bus.d_addr[31:ADDR_WIDTH+2], bus.i_addr[31:ADDR_WIDTH+2], bus.i_addr[1:0]};

  always_comb begin
    lane_mask = 4'b1111;
    nbytes    = 3'd4;
    case (bus.d_size)
      2'b00: begin lane_mask = 4'b0001; nbytes = 3'd1; end
      2'b01: begin lane_mask = 4'b0011; nbytes = 3'd2; end
      default: ;
    endcase
  end

`ifdef RIPCPU_RAM_MISALIGN_EN
  logic crossing;
  assign crossing = ({1'b0, off} + nbytes) > 3'd4;
  assign err      = (bus.d_size == 2'b11);
  assign split_go = crossing && !err;
`else
  assign err      = (bus.d_size == 2'b11) || (({1'b0, off} & (nbytes - 3'd1)) != 3'd0);
  assign split_go = 1'b0;
`endif

  assign bus.d_ready = !rst && (state == IDLE);
  assign accept      = bus.d_req && bus.d_ready;
  // Lanes and data laid out across a word pair; the upper half only matters when split
  assign be_pair     = {4'b0000, lane_mask} << off;
  assign wdata_pair  = {32'd0, bus.d_wdata} << {off, 3'b000};

  always_comb begin
    wr_en   = accept && bus.d_we && !err;
    wr_idx  = d_word;
    wr_be   = be_pair[3:0];
    wr_data = wdata_pair[31:0];
    rd_idx  = d_word;
    if (state == SPLIT) begin
      wr_en   = sv_we && !rst;
      wr_idx  = hi_word;
      wr_be   = hi_be;
      wr_data = hi_data;
      rd_idx  = hi_word;
    end
  end

  assign rd_word = mem[rd_idx];

  function automatic logic [31:0] extend(input logic [63:0] pair, input logic [1:0] o,
                                         input logic [1:0] size, input logic uns);
    logic [31:0] s;
    s = 32'(pair >> {o, 3'b000});
    case (size)
      2'b00:   extend = uns ? {24'd0, s[7:0]}  : {{24{s[7]}}, s[7:0]};
      2'b01:   extend = uns ? {16'd0, s[15:0]} : {{16{s[15]}}, s[15:0]};
      default: extend = s;
    endcase
  endfunction

  // Read-first: reads above see the array before these nonblocking writes land
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && accept) begin
      lo_data     <= rd_word;
      hi_word     <= d_word + ADDR_WIDTH'(1);
      hi_be       <= be_pair[7:4];
      hi_data     <= wdata_pair[63:32];
      sv_off      <= off;
      sv_size     <= bus.d_size;
      sv_unsigned <= bus.d_unsigned;
      sv_we       <= bus.d_we;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      bus.i_valid <= 1'b0;
      bus.i_rdata <= '0;
      bus.d_valid <= 1'b0;
      bus.d_err   <= 1'b0;
      bus.d_rdata <= '0;
    end else begin
      bus.i_valid <= bus.i_req;
      if (bus.i_req) bus.i_rdata <= mem[i_word];
      bus.d_valid <= 1'b0;
      bus.d_err   <= 1'b0;
      bus.d_rdata <= '0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (split_go) begin
              state <= SPLIT;
            end else begin
              bus.d_valid <= 1'b1;
              bus.d_err   <= err;
              if (!err && !bus.d_we)
                bus.d_rdata <= extend({32'd0, rd_word}, off, bus.d_size, bus.d_unsigned);
            end
          end
        end
        SPLIT: begin
          state       <= IDLE;
          bus.d_valid <= 1'b1;
          if (!sv_we) bus.d_rdata <= extend({rd_word, lo_data}, sv_off, sv_size, sv_unsigned);
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
